// File: rtl/rx_nibble_streamer.sv
// rtl/rx_nibble_streamer.sv - serialises 24-bit RX sample words into MSB-first nibbles
// Optional: define RX_FRAME_MARK_EN to append a 4'hA marker nibble after each tlast word.
module rx_nibble_streamer #(
    parameter int HI_LEVEL = 256,
    parameter int LO_LEVEL = 64,
    parameter int LW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic [LW-1:0] s_tlength,
    input  logic          nib_req,
    output logic [3:0]    nib_data,
    output logic          nib_last,
    output logic          samples_rdy,
    output logic          underrun,
    input  logic          clr_status
);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [LW-1:0] HI_L = LW'(HI_LEVEL);
    localparam logic [LW-1:0] LO_L = LW'(LO_LEVEL);

    logic [0:0]  hold_q, hold_d;
    logic [23:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        lastf_q, lastf_d;
    logic [3:0]  nib_data_q, nib_data_d;
    logic        nib_last_q, nib_last_d;
    logic        underrun_q, underrun_d;
    logic        rdy_q, rdy_d;

    logic [2:0]  end_cnt;
    logic        at_end;
    logic        pop;
    logic [3:0]  nib_sel;

`ifdef RX_FRAME_MARK_EN
    // tlast words carry one extra marker nibble, so their final index is 6
    assign end_cnt = lastf_q ? 3'd6 : 3'd5;
`else
    assign end_cnt = 3'd5;
`endif

    assign at_end   = (cnt_q == end_cnt);
    assign s_tready = (hold_q == ST_EMPTY) || (nib_req && at_end);
    assign pop      = s_tvalid && s_tready;

    always_comb begin
        nib_sel = 4'h0;
        case (cnt_q)
            3'd0:    nib_sel = sh_q[23:20];
            3'd1:    nib_sel = sh_q[19:16];
            3'd2:    nib_sel = sh_q[15:12];
            3'd3:    nib_sel = sh_q[11:8];
            3'd4:    nib_sel = sh_q[7:4];
            3'd5:    nib_sel = sh_q[3:0];
`ifdef RX_FRAME_MARK_EN
            default: nib_sel = 4'hA;
`else
            default: nib_sel = 4'h0;
`endif
        endcase
    end

    always_comb begin
        hold_d     = hold_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        lastf_d    = lastf_q;
        nib_data_d = nib_data_q;
        nib_last_d = nib_last_q;
        underrun_d = underrun_q;
        rdy_d      = rdy_q;

        if (nib_req) begin
            if (hold_q == ST_ACTIVE) begin
                nib_data_d = nib_sel;
                nib_last_d = lastf_q && at_end;
                cnt_d      = cnt_q + 3'd1;
                if (at_end) hold_d = ST_EMPTY;
            end else begin
                nib_data_d = 4'h0;
                nib_last_d = 1'b0;
            end
        end

        // A pop overrides the end-of-word release, giving back-to-back words with no bubble
        if (pop) begin
            sh_d    = s_tdata;
            lastf_d = s_tlast;
            cnt_d   = 3'd0;
            hold_d  = ST_ACTIVE;
        end

        if (clr_status) underrun_d = 1'b0;
        if (nib_req && (hold_q == ST_EMPTY)) underrun_d = 1'b1;

        if (!rdy_q && (s_tlength > HI_L)) rdy_d = 1'b1;
        else if (rdy_q && (s_tlength <= LO_L)) rdy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= ST_EMPTY;
            sh_q       <= 24'h0;
            cnt_q      <= 3'd0;
            lastf_q    <= 1'b0;
            nib_data_q <= 4'h0;
            nib_last_q <= 1'b0;
            underrun_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            lastf_q    <= lastf_d;
            nib_data_q <= nib_data_d;
            nib_last_q <= nib_last_d;
            underrun_q <= underrun_d;
            rdy_q      <= rdy_d;
        end
    end

    assign nib_data    = nib_data_q;
    assign nib_last    = nib_last_q;
    assign underrun    = underrun_q;
    assign samples_rdy = rdy_q;

endmodule

// File: tb/tb_rx_nibble_streamer.sv
// tb/tb_rx_nibble_streamer.sv - directed self-checking bench for rx_nibble_streamer
module tb_rx_nibble_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [10:0] s_tlength;
    logic        nib_req;
    logic [3:0]  nib_data;
    logic        nib_last;
    logic        samples_rdy;
    logic        underrun;
    logic        clr_status;

    int vec_cnt = 0;
    int err_cnt = 0;
    int pop_cnt = 0;

    logic [24:0] fmem [0:15];
    logic [3:0]  wr_p = 4'd0;
    logic [3:0]  rd_p = 4'd0;

    always #5 clk = ~clk;

    assign s_tvalid = (wr_p != rd_p);
    assign s_tdata  = fmem[rd_p][23:0];
    assign s_tlast  = fmem[rd_p][24];

    always @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            rd_p    <= rd_p + 4'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    rx_nibble_streamer dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tlength(s_tlength),
        .nib_req(nib_req), .nib_data(nib_data), .nib_last(nib_last),
        .samples_rdy(samples_rdy), .underrun(underrun), .clr_status(clr_status)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [23:0] d, input logic l);
        fmem[wr_p] = {l, d};
        wr_p = wr_p + 4'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; nib_req = 1'b0; clr_status = 1'b0; s_tlength = '0;
        step(); step();
        rst = 1'b0;
        vec_cnt++;
        if ({nib_data, nib_last, samples_rdy, underrun, s_tready} !== 8'b0000_0001) begin
            err_cnt++;
            $display("FAIL reset: got %b want 00000001", {nib_data, nib_last, samples_rdy, underrun, s_tready});
        end
    endtask

    task automatic test_single_word();
        logic [3:0] exp [0:5];
        int p0;
        exp[0] = 4'hA; exp[1] = 4'hB; exp[2] = 4'hC; exp[3] = 4'h1; exp[4] = 4'h2; exp[5] = 4'h3;
        p0 = pop_cnt;
        push(24'hABC123, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            nib_req = 1'b1; step(); nib_req = 1'b0;
            vec_cnt++;
            if (nib_data !== exp[i] || nib_last !== 1'b0) begin
                err_cnt++;
                $display("FAIL single_nib%0d: got %h/%b want %h/0", i, nib_data, nib_last, exp[i]);
            end
            step(); step();
            vec_cnt++;
            if (nib_data !== exp[i]) begin
                err_cnt++;
                $display("FAIL single_hold%0d: got %h want %h", i, nib_data, exp[i]);
            end
        end
        vec_cnt++;
        if (pop_cnt - p0 !== 1 || s_tready !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_pops: got pops=%0d ready=%b want 1/1", pop_cnt - p0, s_tready);
        end
    endtask

    task automatic test_back_to_back();
        int p0, n;
`ifdef RX_FRAME_MARK_EN
        n = 13;
`else
        n = 12;
`endif
        push(24'h123456, 1'b0);
        push(24'h789ABC, 1'b1);
        step();
        p0 = pop_cnt;
        nib_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [3:0] e;
            step();
            e = (i == 12) ? 4'hA : 4'(i + 1);
            vec_cnt++;
            if (nib_data !== e || nib_last !== (i == n - 1)) begin
                err_cnt++;
                $display("FAIL b2b_nib%0d: got %h/%b want %h/%b", i, nib_data, nib_last, e, (i == n - 1));
            end
            if (i == 4 || i == 5) begin
                vec_cnt++;
                if (pop_cnt - p0 !== i - 4) begin
                    err_cnt++;
                    $display("FAIL b2b_pop%0d: got %0d want %0d", i, pop_cnt - p0, i - 4);
                end
            end
        end
        nib_req = 1'b0;
    endtask

    task automatic test_underrun();
        nib_req = 1'b1; step(); nib_req = 1'b0;
        vec_cnt++;
        if (nib_data !== 4'h0 || nib_last !== 1'b0 || underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL underrun_set: got %h/%b/%b want 0/0/1", nib_data, nib_last, underrun);
        end
        nib_req = 1'b1; clr_status = 1'b1; step(); nib_req = 1'b0;
        vec_cnt++;
        if (underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL underrun_setwins: got %b want 1", underrun);
        end
        step();
        clr_status = 1'b0;
        vec_cnt++;
        if (underrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL underrun_clr: got %b want 0", underrun);
        end
    endtask

    task automatic test_hysteresis();
        logic [10:0] lv [0:6];
        logic        ev [0:6];
        lv[0] = 11'd0;   ev[0] = 1'b0;
        lv[1] = 11'd256; ev[1] = 1'b0;
        lv[2] = 11'd257; ev[2] = 1'b1;
        lv[3] = 11'd300; ev[3] = 1'b1;
        lv[4] = 11'd100; ev[4] = 1'b1;
        lv[5] = 11'd65;  ev[5] = 1'b1;
        lv[6] = 11'd64;  ev[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tlength = lv[i];
            step();
            vec_cnt++;
            if (samples_rdy !== ev[i]) begin
                err_cnt++;
                $display("FAIL rdy_len%0d: got %b want %b", lv[i], samples_rdy, ev[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        push(24'hFEDCBA, 1'b0);
        s_tlength = 11'd300;
        step();
        for (int i = 0; i < 3; i++) begin
            nib_req = 1'b1; step(); nib_req = 1'b0;
        end
        vec_cnt++;
        if (nib_data !== 4'hD || samples_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_pre: got %h/%b want d/1", nib_data, samples_rdy);
        end
        rst = 1'b1; s_tlength = '0; step(); rst = 1'b0;
        vec_cnt++;
        if ({nib_data, nib_last, samples_rdy, underrun, s_tready} !== 8'b0000_0001) begin
            err_cnt++;
            $display("FAIL midrst_out: got %b want 00000001", {nib_data, nib_last, samples_rdy, underrun, s_tready});
        end
        push(24'h5A3C96, 1'b0);
        step();
        nib_req = 1'b1; step(); nib_req = 1'b0;
        vec_cnt++;
        if (nib_data !== 4'h5 || underrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_next: got %h/%b want 5/0", nib_data, underrun);
        end
        for (int i = 0; i < 5; i++) begin
            nib_req = 1'b1; step(); nib_req = 1'b0;
        end
        vec_cnt++;
        if (nib_data !== 4'h6) begin
            err_cnt++;
            $display("FAIL midrst_tail: got %h want 6", nib_data);
        end
    endtask

    task automatic test_frame_mark();
        logic [3:0] exp [0:6];
        int n;
        exp[0] = 4'h0; exp[1] = 4'h0; exp[2] = 4'h0; exp[3] = 4'h0;
        exp[4] = 4'h0; exp[5] = 4'h1; exp[6] = 4'hA;
`ifdef RX_FRAME_MARK_EN
        n = 7;
`else
        n = 6;
`endif
        push(24'h000001, 1'b1);
        step();
        for (int i = 0; i < n; i++) begin
            nib_req = 1'b1; step(); nib_req = 1'b0; step();
            vec_cnt++;
            if (nib_data !== exp[i] || nib_last !== (i == n - 1)) begin
                err_cnt++;
                $display("FAIL frame_nib%0d: got %h/%b want %h/%b", i, nib_data, nib_last, exp[i], (i == n - 1));
            end
        end
        vec_cnt++;
        if (s_tready !== 1'b1 || underrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL frame_done: got ready=%b underrun=%b want 1/0", s_tready, underrun);
        end
    endtask

    initial begin
        rst = 1'b1; nib_req = 1'b0; clr_status = 1'b0; s_tlength = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_hysteresis();
        test_mid_reset();
        test_frame_mark();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
